// File: rtl/opensync_rx_timestamp_classify.sv
// Receive-side timestamp and PTP/PCF classifier.
// Each frame is stamped with local time at its first byte and classified from
// its EtherType and PTP messageType. The byte stream is delayed by a fixed
// latency so the metadata is stable for the whole output frame.
module opensync_rx_timestamp_classify #(
   parameter int unsigned DELAY_CYCLES = 24,
   parameter int unsigned PREAMBLE_LEN = 8,
   parameter logic [15:0] PTP_ETYPE    = 16'h88F7,
   parameter logic [15:0] PCF_ETYPE    = 16'h891D
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [7:0]  iv_data,
   input  logic        i_data_wr,
   input  logic [63:0] iv_local_time,
   output logic [7:0]  ov_data,
   output logic        o_data_wr,
   output logic [63:0] ov_receive_time,
   output logic        o_cf_update_flag,
   output logic        o_tsn_or_tte,
   output logic        o_meta_overflow
);

   localparam logic [10:0] CNT_ET_HI = 11'(PREAMBLE_LEN + 12);
   localparam logic [10:0] CNT_ET_LO = 11'(PREAMBLE_LEN + 13);
   localparam logic [10:0] CNT_MSG   = 11'(PREAMBLE_LEN + 14);
   localparam logic [10:0] CNT_MAX   = 11'h7FF;

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_PUSH, S_BODY} state_t;

   state_t      state_q;
   logic [10:0] cnt_q;
   logic [10:0] cnt_inc;
   logic [63:0] rx_time_q;
   logic [15:0] etype_q;
   logic        flag_q;
   logic        tsn_q;
   logic        ended_q;
   logic        armed_q;
   logic        in_valid;
   logic        flag_c;
   logic        tsn_c;

   logic [8:0]  dly_q [DELAY_CYCLES];

   logic [65:0] fifo_q [2];
   logic        wr_ptr_q;
   logic        rd_ptr_q;
   logic [1:0]  count_q;
   logic        owr_prev_q;
   logic [65:0] meta_q;
   logic        ovf_q;

   logic        push;
   logic        pop;
   logic        push_ok;
   logic        ovf_d;
   logic        rd_nxt;
   logic [1:0]  count_d;
   logic [65:0] push_data;
   logic [65:0] head_d;
   logic [65:0] meta_d;

   // Bytes of a frame already running when reset was released stay masked
   // until the line has been seen idle once.
   assign in_valid = i_data_wr & armed_q;
   assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 11'd1;

   // Classification from the captured EtherType and the messageType nibble.
   always_comb begin
      flag_c = 1'b0;
      tsn_c  = 1'b0;
      if (etype_q == PTP_ETYPE) begin
         tsn_c  = 1'b1;
         flag_c = (iv_data[3:0] < 4'd4);
      end else if (etype_q == PCF_ETYPE) begin
         flag_c = 1'b1;
      end
   end

   // Masking flag for frames in flight across a reset release.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)        armed_q <= 1'b0;
      else if (!i_data_wr) armed_q <= 1'b1;
   end

   // Fixed-latency {valid, byte} delay line, shifting every cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned i = 0; i < DELAY_CYCLES; i++) dly_q[i] <= '0;
      end else begin
         dly_q[0] <= {in_valid, iv_data};
         for (int unsigned i = 1; i < DELAY_CYCLES; i++) dly_q[i] <= dly_q[i-1];
      end
   end

   assign ov_data   = dly_q[DELAY_CYCLES-1][7:0];
   assign o_data_wr = dly_q[DELAY_CYCLES-1][8];

   // Frame FSM: latches the receive time, counts bytes and classifies the header.
   // A frame ending inside the header leaves ended_q set, so a new frame that
   // begins during the PUSH cycle (one idle cycle gap) is started from PUSH.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rx_time_q <= '0;
         etype_q   <= '0;
         flag_q    <= 1'b0;
         tsn_q     <= 1'b0;
         ended_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  cnt_q     <= 11'd1;
                  rx_time_q <= iv_local_time;
                  state_q   <= S_HDR;
               end
            end
            S_HDR: begin
               if (!in_valid) begin
                  flag_q  <= 1'b0;
                  tsn_q   <= 1'b0;
                  ended_q <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= S_PUSH;
               end else begin
                  cnt_q <= cnt_inc;
                  if (cnt_q == CNT_ET_HI) etype_q[15:8] <= iv_data;
                  if (cnt_q == CNT_ET_LO) etype_q[7:0]  <= iv_data;
                  if (cnt_q == CNT_MSG) begin
                     flag_q  <= flag_c;
                     tsn_q   <= tsn_c;
                     ended_q <= 1'b0;
                     state_q <= S_PUSH;
                  end
               end
            end
            S_PUSH: begin
               if (in_valid && ended_q) begin
                  cnt_q     <= 11'd1;
                  rx_time_q <= iv_local_time;
                  state_q   <= S_HDR;
               end else if (in_valid) begin
                  cnt_q   <= cnt_inc;
                  state_q <= S_BODY;
               end else begin
                  cnt_q   <= '0;
                  state_q <= S_IDLE;
               end
            end
            S_BODY: begin
               if (in_valid) begin
                  cnt_q <= cnt_inc;
               end else begin
                  cnt_q   <= '0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Metadata FIFO next state; the presentation registers track the head
   // as it will be after this cycle's push/pop.
   always_comb begin
      push      = (state_q == S_PUSH);
      pop       = owr_prev_q & ~o_data_wr & (count_q != 2'd0);
      push_ok   = push & ((count_q != 2'd2) | pop);
      ovf_d     = push & (count_q == 2'd2) & ~pop;
      rd_nxt    = rd_ptr_q ^ pop;
      count_d   = count_q + 2'(push_ok) - 2'(pop);
      push_data = {rx_time_q, flag_q, tsn_q};
      head_d    = (push_ok && (wr_ptr_q == rd_nxt)) ? push_data : fifo_q[rd_nxt];
      meta_d    = (count_d != 2'd0) ? head_d : meta_q;
   end

   // FIFO storage, pointers, presentation registers and overflow pulse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= '0;
         owr_prev_q <= 1'b0;
         meta_q     <= '0;
         ovf_q      <= 1'b0;
      end else begin
         if (push_ok) begin
            fifo_q[wr_ptr_q] <= push_data;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         rd_ptr_q   <= rd_nxt;
         count_q    <= count_d;
         owr_prev_q <= o_data_wr;
         meta_q     <= meta_d;
         ovf_q      <= ovf_d;
      end
   end

   assign ov_receive_time  = meta_q[65:2];
   assign o_cf_update_flag = meta_q[1];
   assign o_tsn_or_tte     = meta_q[0];
   assign o_meta_overflow  = ovf_q;

endmodule

// File: tb/tb_opensync_rx_timestamp_classify.sv
// Directed bench for opensync_rx_timestamp_classify: a table of frames is
// driven and a scoreboard monitor checks latency, bytes and metadata of every
// output frame; reset-mid-frame is a hand-written sequence.
module tb_opensync_rx_timestamp_classify;

   localparam int DLY = 24;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  din   = '0;
   logic        wr    = 1'b0;
   logic [63:0] lt    = '0;
   logic [7:0]  ov_data;
   logic        o_data_wr;
   logic [63:0] ov_receive_time;
   logic        o_cf_update_flag;
   logic        o_tsn_or_tte;
   logic        o_meta_overflow;

   int cyc     = 0;
   int errs    = 0;
   int chks    = 0;
   int ovf_cnt = 0;
   int spur    = 0;

   typedef struct {
      int          len;
      logic [15:0] et;
      logic [7:0]  b22;
      logic [63:0] t0;
      int          gap;
      logic        fl;
      logic        ts;
   } vec_t;

   typedef struct {
      int          id;
      int          start;
      int          olen;
      logic [15:0] et;
      logic [7:0]  b22;
      logic [63:0] t0;
      logic        fl;
      logic        ts;
   } exp_t;

   exp_t exp_q[$];
   vec_t vecs[15];

   opensync_rx_timestamp_classify #(
      .DELAY_CYCLES(DLY),
      .PREAMBLE_LEN(8),
      .PTP_ETYPE(16'h88F7),
      .PCF_ETYPE(16'h891D)
   ) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .iv_data          (din),
      .i_data_wr        (wr),
      .iv_local_time    (lt),
      .ov_data          (ov_data),
      .o_data_wr        (o_data_wr),
      .ov_receive_time  (ov_receive_time),
      .o_cf_update_flag (o_cf_update_flag),
      .o_tsn_or_tte     (o_tsn_or_tte),
      .o_meta_overflow  (o_meta_overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
      chks++;
      if (act !== expv) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   function automatic logic [7:0] gen_byte(input int id, input int i,
                                           input logic [15:0] et, input logic [7:0] b22);
      if (i < 7)   return 8'h55;
      if (i == 7)  return 8'hD5;
      if (i == 20) return et[15:8];
      if (i == 21) return et[7:0];
      if (i == 22) return b22;
      return 8'((id * 37 + i * 13) & 255);
   endfunction

   task automatic send_frame(input vec_t v, input int id, input int olen);
      exp_t e;
      for (int i = 0; i < v.len; i++) begin
         @(posedge clk); #1;
         din = gen_byte(id, i, v.et, v.b22);
         wr  = 1'b1;
         lt  = v.t0 + 64'(i);
         if (i == 0) begin
            e.id = id; e.start = cyc; e.olen = olen; e.et = v.et; e.b22 = v.b22;
            e.t0 = v.t0; e.fl = v.fl; e.ts = v.ts;
            exp_q.push_back(e);
         end
      end
      for (int g = 0; g < v.gap; g++) begin
         @(posedge clk); #1;
         wr  = 1'b0;
         din = 8'h00;
         lt  = lt + 64'd1;
      end
   endtask

   task automatic monitor();
      exp_t        e;
      bit          active = 1'b0;
      bit          skip   = 1'b0;
      int          k = 0, derr = 0, mbad = 0;
      logic [63:0] mt;
      logic        mf, ms;
      forever begin
         @(negedge clk);
         if (o_meta_overflow) ovf_cnt++;
         if (o_data_wr && !active && !skip) begin
            if (exp_q.size() == 0) begin
               spur++;
               skip = 1'b1;
            end else begin
               e = exp_q.pop_front();
               active = 1'b1; k = 0; derr = 0; mbad = 0;
               mt = ov_receive_time; mf = o_cf_update_flag; ms = o_tsn_or_tte;
               check($sformatf("f%0d_latency", e.id), 64'(cyc - e.start), 64'(DLY));
               check($sformatf("f%0d_rx_time", e.id), ov_receive_time, e.t0);
               check($sformatf("f%0d_flag", e.id), 64'(o_cf_update_flag), 64'(e.fl));
               check($sformatf("f%0d_tsn", e.id), 64'(o_tsn_or_tte), 64'(e.ts));
            end
         end
         if (o_data_wr && active) begin
            if (ov_data !== gen_byte(e.id, k, e.et, e.b22)) derr++;
            if (ov_receive_time !== mt || o_cf_update_flag !== mf || o_tsn_or_tte !== ms) mbad++;
            k++;
         end else if (!o_data_wr) begin
            if (active) begin
               check($sformatf("f%0d_length", e.id), 64'(k), 64'(e.olen));
               check($sformatf("f%0d_data_errs", e.id), 64'(derr), 64'd0);
               check($sformatf("f%0d_meta_changes", e.id), 64'(mbad), 64'd0);
            end
            active = 1'b0;
            skip   = 1'b0;
         end
      end
   endtask

   task automatic check_outputs_zero(input string pfx);
      check({pfx, "_o_data_wr"}, 64'(o_data_wr), 64'd0);
      check({pfx, "_ov_data"}, 64'(ov_data), 64'd0);
      check({pfx, "_rx_time"}, ov_receive_time, 64'd0);
      check({pfx, "_flag"}, 64'(o_cf_update_flag), 64'd0);
      check({pfx, "_tsn"}, 64'(o_tsn_or_tte), 64'd0);
      check({pfx, "_overflow"}, 64'(o_meta_overflow), 64'd0);
   endtask

   initial begin
      exp_t e;
      vecs[0]  = '{90, 16'h88F7, 8'h00, 64'h1000, 5, 1'b1, 1'b1};  // Sync
      vecs[1]  = '{90, 16'h88F7, 8'h08, 64'h1100, 5, 1'b0, 1'b1};  // Follow_Up
      vecs[2]  = '{72, 16'h891D, 8'h12, 64'h1200, 5, 1'b1, 1'b0};  // PCF
      vecs[3]  = '{72, 16'h0800, 8'h45, 64'h1300, 5, 1'b0, 1'b0};  // IPv4
      vecs[4]  = '{72, 16'h88F7, 8'h01, 64'h2000, 1, 1'b1, 1'b1};  // back-to-back A
      vecs[5]  = '{72, 16'h891D, 8'h00, 64'h2049, 5, 1'b1, 1'b0};  // back-to-back B
      vecs[6]  = '{18, 16'h88F7, 8'h00, 64'h3000, 1, 1'b0, 1'b0};  // runt
      vecs[7]  = '{90, 16'h88F7, 8'h00, 64'h3013, 5, 1'b1, 1'b1};  // Sync after runt
      vecs[8]  = '{64, 16'h88F7, 8'h13, 64'h4000, 1, 1'b1, 1'b1};  // Pdelay_Resp, high nibble set
      vecs[9]  = '{64, 16'h88F7, 8'h04, 64'h4041, 5, 1'b0, 1'b1};  // non-event PTP
      vecs[10] = '{64, 16'h8100, 8'h00, 64'h4100, 5, 1'b0, 1'b0};  // VLAN tagged
      vecs[11] = '{23, 16'h88F7, 8'h02, 64'h4500, 1, 1'b1, 1'b1};  // ends exactly at E+2
      vecs[12] = '{22, 16'h88F7, 8'h00, 64'h4600, 1, 1'b0, 1'b0};  // ends before E+2
      vecs[13] = '{64, 16'h0800, 8'h45, 64'h4700, 40, 1'b0, 1'b0}; // IPv4
      vecs[14] = '{90, 16'h88F7, 8'h00, 64'h6000, 5, 1'b1, 1'b1};  // after reset

      fork
         monitor();
      join_none

      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_outputs_zero("reset");
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);

      for (int v = 0; v < 14; v++) send_frame(vecs[v], v, vecs[v].len);

      // Reset asserted while byte 40 of a PTP frame is on the input; only the
      // 16 bytes already delivered may appear, the rest of the frame is dropped.
      for (int i = 0; i < 90; i++) begin
         @(posedge clk); #1;
         din = gen_byte(20, i, 16'h88F7, 8'h00);
         wr  = 1'b1;
         lt  = 64'h5000 + 64'(i);
         if (i == 0) begin
            e.id = 20; e.start = cyc; e.olen = 16; e.et = 16'h88F7; e.b22 = 8'h00;
            e.t0 = 64'h5000; e.fl = 1'b1; e.ts = 1'b1;
            exp_q.push_back(e);
         end
         if (i == 40) begin
            #1 rst_n = 1'b0;
            #1 check_outputs_zero("midframe_reset");
         end
         if (i == 43) #1 rst_n = 1'b1;
      end
      for (int g = 0; g < 40; g++) begin
         @(posedge clk); #1;
         wr  = 1'b0;
         din = 8'h00;
      end
      check("after_reset_o_data_wr", 64'(o_data_wr), 64'd0);

      send_frame(vecs[14], 14, vecs[14].len);

      for (int w = 0; w < 400 && (exp_q.size() != 0 || o_data_wr); w++) @(negedge clk);
      repeat (4) @(negedge clk);
      check("frames_not_seen", 64'(exp_q.size()), 64'd0);
      check("spurious_frames", 64'(spur), 64'd0);
      check("overflow_pulses", 64'(ovf_cnt), 64'd0);

      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end

endmodule
